regfile_dump_reader: RTL and testbench
======================================

// Module: regfile_dump_reader
// PURPOSE
//  Read-side sequencer for the register file: on a start command it walks an
//  inclusive address range through one regfile read port. Each word goes out
//  on a valid/ready stream, tagged with its index. Used for debug dump,
//  context save and scan-out. It never writes the regfile.
// PARAMETERS
//  WIDTH  16  data word width; must match the regfile
//  DEPTH  8   regfile entries; AW = $clog2(DEPTH)
// PORTS
//  clk        in   1      rising-edge clock, single domain
//  rst        in   1      asynchronous reset, active-high
//  start      in   1      1-cycle request; sampled only in IDLE
//  first_addr in   AW     first entry to read, latched on accepted start
//  last_addr  in   AW     last entry to read (inclusive), latched on start
//  abort      in   1      synchronous abort of a dump in progress
//  rd_addr    out  AW     to regfile read_reg port (registered)
//  rd_data    in   WIDTH  from regfile read_out port (combinational read)
//  out_valid  out  1      stream word valid
//  out_ready  in   1      downstream ready
//  out_data   out  WIDTH  stream word
//  out_index  out  AW     regfile address of out_data
//  out_last   out  1      out_data is the final word of the range
//  busy       out  1      high in every state except IDLE
//  done       out  1      1-cycle pulse after the last word handshakes
// BEHAVIOUR
//  Reset: state=IDLE; rd_addr, out_data, out_index = 0;
//   out_valid, out_last, busy, done = 0.
//  States: IDLE, LOAD, SEND, DONE.
//  IDLE: start=1 -> latch first/last, rd_addr<=first_addr, go to LOAD.
//  LOAD (1 cycle): out_data<=rd_data, out_index<=rd_addr,
//   out_last<=(rd_addr==last_q), out_valid<=1, go to SEND.
//  SEND: hold out_* stable while out_valid && !out_ready.
//   On handshake: out_valid<=0.
//   If out_last -> DONE. Else rd_addr<=next(rd_addr) and go to LOAD.
//  DONE (1 cycle): done=1, go to IDLE. busy is low from the next cycle.
//  Throughput: at most 1 word per 2 cycles.
//   Latency: start accepted -> first out_valid = 2 cycles.
//  next(a) = (a==DEPTH-1) ? 0 : a+1. The range wraps when last < first;
//   e.g. first=6, last=1 reads 6,7,0,1. first==last reads exactly 1 word.
//   Words per dump = ((last-first) mod DEPTH) + 1, so 1..DEPTH words.
//  Coherence: a word is sampled at the LOAD clock edge. A regfile write to
//   the same address at that edge is NOT visible (pre-write value).
//   Writes to entries not yet loaded are visible.
//  start while busy: ignored. The latched range is unchanged.
//  abort (any non-IDLE state): next state is IDLE. out_valid and out_last
//   drop to 0 and done is not pulsed. abort has priority over a handshake in
//   the same cycle. abort in IDLE has no effect; abort+start in IDLE gives
//   IDLE.
//  Addresses >= DEPTH (DEPTH not a power of 2) are clamped to DEPTH-1 at latch.
//  rst asserted mid-dump: immediate return to reset values; no done pulse.
// STRUCTURE
//  Shared package regfile_pkg: state encodings (IDLE=0, LOAD=1, SEND=2,
//   DONE=3) and the AW function, also used by the regfile write side.
//  Sub-module dump_addr_ctr: modulo-DEPTH address register with load,
//   increment and at-last compare. The FSM and output register stay in this
//   module.
// TESTING (WIDTH=16, DEPTH=8; entry i preloaded with 16'hA0+i)
//  1. first=0, last=7, out_ready=1 -> 8 words A0..A7, index 0..7, out_last
//     only on index 7, done 1 cycle later, 16 cycles start->last handshake.
//  2. first=6, last=1 -> words A6,A7,A0,A1 (wrap), then a single done pulse.
//  3. first=3, last=3, out_ready=0 for 5 cycles -> A3 held stable with
//     out_valid=1; completes on the 6th cycle; out_last=1.
//  4. Regfile write of 16'hBEEF to entry 2 while LOAD is at entry 2 ->
//     out_data=A2; a later dump of entry 2 returns BEEF.
//  5. abort asserted during SEND of the 3rd word -> IDLE next cycle,
//     out_valid=0, no done; a new start then dumps normally.
//  6. start pulsed while busy -> ignored. rst mid-dump -> all outputs 0;
//     the next start restarts from the new first_addr.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its read-side dump sequencer:
// dump FSM state encodings and the address-width helper.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } dump_state_e;

  // Address width for a given entry count; never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dump_addr_ctr.sv
// Modulo-DEPTH read address register for the dump sequencer: loads the range,
// steps with wrap-around and flags when the current address is the last one.
module dump_addr_ctr
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_first,
  input  logic [AW-1:0] i_last,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic          o_at_last
);

  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_last;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  function automatic logic [AW-1:0] clamp_addr(input logic [AW-1:0] a);
    logic [AW:0] ext;
    ext = {1'b0, a};
    return (ext > (AW+1)'(DEPTH - 1)) ? AW'(DEPTH - 1) : a;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_last <= '0;
    end else if (i_load) begin
      r_addr <= clamp_addr(i_first);
      r_last <= clamp_addr(i_last);
    end else if (i_inc) begin
      r_addr <= (r_addr == AW'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
    end
  end

  assign o_addr    = r_addr;
  assign o_at_last = (r_addr == r_last);

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer: walks an inclusive, wrapping address range through
// one regfile read port and streams each word with its index on valid/ready.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    first_addr,
  input  logic [AW-1:0]    last_addr,
  input  logic             abort,
  output logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  dump_state_e      r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [AW-1:0]    r_out_index;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;

  logic [AW-1:0]    w_addr;
  logic             w_at_last;
  logic             w_load;
  logic             w_inc;
  logic             w_handshake;

  assign w_handshake = r_out_valid && out_ready;
  assign w_load      = (r_state == ST_IDLE) && start && !abort;
  assign w_inc       = (r_state == ST_SEND) && !abort && w_handshake && !r_out_last;

  dump_addr_ctr #(
    .DEPTH(DEPTH)
  ) u_addr_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_first  (first_addr),
    .i_last   (last_addr),
    .i_inc    (w_inc),
    .o_addr   (w_addr),
    .o_at_last(w_at_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != ST_IDLE && abort) begin
        // Abort wins over any handshake in the same cycle and suppresses done.
        r_state     <= ST_IDLE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_load) begin
              r_state <= ST_LOAD;
              r_busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            // The word is captured here, so a same-edge regfile write is not seen.
            r_out_data  <= rd_data;
            r_out_index <= w_addr;
            r_out_last  <= w_at_last;
            r_out_valid <= 1'b1;
            r_state     <= ST_SEND;
          end
          ST_SEND: begin
            if (w_handshake) begin
              r_out_valid <= 1'b0;
              if (r_out_last) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_LOAD;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_addr   = w_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with a small regfile model:
// table-driven dumps, hand-written corner sequences and random dumps.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  first_addr = '0;
  logic [2:0]  last_addr = '0;
  logic        abort = 1'b0;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  // Regfile stand-in: synchronous write, combinational read.
  logic [15:0] mem [8];
  logic        we = 1'b0;
  logic [2:0]  wa = '0;
  logic [15:0] wd = '0;
  logic [15:0] model_mem [8];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (we) mem[wa] <= wd;
  assign rd_data = mem[rd_addr];

  regfile_dump_reader #(.WIDTH(16), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .abort     (abort),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [2:0]  first;
    logic [2:0]  last;
    int          rdy_pct;
    int          glitch_c;
    int          exp_words;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_cycles;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(negedge clk);
    we = 1'b0;
    model_mem[a] = d;
  endtask

  // One dump from start to the cycle after done; expected words come from the
  // range rule applied to the model regfile contents.
  task automatic run_dump(input logic [2:0] f, input logic [2:0] l, input int rdy_pct,
                          input int glitch_c, input string nm,
                          output int n_got, output logic [15:0] d_first,
                          output logic [15:0] d_last, output int hs_cycles);
    logic [15:0] exp_d[$];
    logic [2:0]  exp_i[$];
    int n_exp, c, first_valid_c, done_seen;
    logic prev_stall;
    logic [15:0] prev_d;
    logic [2:0] prev_i;
    logic prev_l;
    n_exp = ((int'(l) - int'(f) + 8) % 8) + 1;
    for (int k = 0; k < n_exp; k++) begin
      exp_i.push_back(3'((int'(f) + k) % 8));
      exp_d.push_back(model_mem[(int'(f) + k) % 8]);
    end
    n_got = 0; d_first = '0; d_last = '0; hs_cycles = -1;
    first_valid_c = -1; done_seen = 0; prev_stall = 1'b0;
    prev_d = '0; prev_i = '0; prev_l = 1'b0;
    @(negedge clk);
    start = 1'b1; first_addr = f; last_addr = l;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (n_got < n_exp && c < 200) begin
      if (c == glitch_c) begin
        start = 1'b1; first_addr = f + 3'd3; last_addr = f;
      end else begin
        start = 1'b0;
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      if (done) done_seen++;
      if (out_valid && first_valid_c < 0) first_valid_c = c;
      if (prev_stall) begin
        chk({nm, " hold_valid"}, out_valid, 1'b1);
        chk({nm, " hold_data"}, out_data, prev_d);
        chk({nm, " hold_index"}, out_index, prev_i);
        chk({nm, " hold_last"}, out_last, prev_l);
      end
      if (out_valid && out_ready) begin
        chk({nm, " data"}, out_data, exp_d[n_got]);
        chk({nm, " index"}, out_index, exp_i[n_got]);
        chk({nm, " last"}, out_last, (n_got == n_exp - 1));
        if (n_got == 0) d_first = out_data;
        d_last = out_data;
        n_got++;
        hs_cycles = c;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_i = out_index; prev_l = out_last;
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk({nm, " word_count"}, n_got, n_exp);
    chk({nm, " first_valid_latency"}, first_valid_c, 2);
    chk({nm, " early_done"}, done_seen, 0);
    chk({nm, " done_pulse"}, done, 1'b1);
    chk({nm, " busy_in_done"}, busy, 1'b1);
    @(negedge clk);
    chk({nm, " done_cleared"}, done, 1'b0);
    chk({nm, " busy_cleared"}, busy, 1'b0);
    $display("dump %s first=%0d last=%0d words=%0d cycles=%0d", nm, f, l, n_got, hs_cycles);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int n_got, hs;
    logic [15:0] d_first, d_last;
    vecs[0] = '{3'd0, 3'd7, 100, 0, 8, 16'hA0, 16'hA7, 16};
    vecs[1] = '{3'd6, 3'd1, 100, 0, 4, 16'hA6, 16'hA1, 8};
    vecs[2] = '{3'd3, 3'd3, 100, 0, 1, 16'hA3, 16'hA3, 2};
    vecs[3] = '{3'd5, 3'd4, 60,  0, 8, 16'hA5, 16'hA4, -1};
    vecs[4] = '{3'd0, 3'd3, 100, 3, 4, 16'hA0, 16'hA3, 8};
    vecs[5] = '{3'd7, 3'd0, 40,  0, 2, 16'hA7, 16'hA0, -1};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst rd_addr", rd_addr, 3'd0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 16'h0);
    chk("rst out_index", out_index, 3'd0);
    chk("rst out_last", out_last, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA0 + 16'(i));

    // Table-driven dumps (entry 4 also pulses start while busy).
    for (int v = 0; v < 6; v++) begin
      run_dump(vecs[v].first, vecs[v].last, vecs[v].rdy_pct, vecs[v].glitch_c,
               $sformatf("vec%0d", v), n_got, d_first, d_last, hs);
      chk($sformatf("vec%0d words", v), n_got, vecs[v].exp_words);
      chk($sformatf("vec%0d first_word", v), d_first, vecs[v].exp_first);
      chk($sformatf("vec%0d last_word", v), d_last, vecs[v].exp_last);
      if (vecs[v].exp_cycles >= 0)
        chk($sformatf("vec%0d cycles", v), hs, vecs[v].exp_cycles);
    end

    // Backpressure: single word held for 5 stalled cycles, accepted on the 6th.
    @(negedge clk);
    start = 1'b1; first_addr = 3'd3; last_addr = 3'd3; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall valid", out_valid, 1'b1);
      chk("stall data", out_data, 16'hA3);
      chk("stall last", out_last, 1'b1);
      @(negedge clk);
    end
    chk("stall valid6", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall done", done, 1'b1);
    chk("stall valid_drop", out_valid, 1'b0);
    @(negedge clk);
    chk("stall busy_end", busy, 1'b0);
    $display("dump stall first=3 last=3 words=1");

    // Write to entry 2 on the same edge that loads entry 2.
    @(negedge clk);
    start = 1'b1; first_addr = 3'd2; last_addr = 3'd2; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; we = 1'b1; wa = 3'd2; wd = 16'hBEEF;
    @(negedge clk);
    we = 1'b0;
    model_mem[2] = 16'hBEEF;
    chk("coherence valid", out_valid, 1'b1);
    chk("coherence pre_write", out_data, 16'hA2);
    @(negedge clk);
    chk("coherence done", done, 1'b1);
    out_ready = 1'b0;
    @(negedge clk);
    run_dump(3'd2, 3'd2, 100, 0, "reread2", n_got, d_first, d_last, hs);
    chk("reread2 beef", d_first, 16'hBEEF);

    // Abort during SEND of the third word, with ready also high.
    @(negedge clk);
    start = 1'b1; first_addr = 3'd0; last_addr = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort third_valid", out_valid, 1'b1);
    chk("abort third_index", out_index, 3'd2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("abort valid", out_valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort last", out_last, 1'b0);
    chk("abort done", done, 1'b0);
    @(negedge clk);
    chk("abort no_done", done, 1'b0);
    $display("dump abort first=0 last=7 words=2");
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start idle_busy", busy, 1'b0);
    @(negedge clk);
    chk("abort_start idle_valid", out_valid, 1'b0);
    run_dump(3'd1, 3'd2, 100, 0, "after_abort", n_got, d_first, d_last, hs);

    // Reset in the middle of a dump.
    @(negedge clk);
    start = 1'b1; first_addr = 3'd4; last_addr = 3'd7; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst rd_addr", rd_addr, 3'd0);
    chk("midrst valid", out_valid, 1'b0);
    chk("midrst data", out_data, 16'h0);
    chk("midrst index", out_index, 3'd0);
    chk("midrst last", out_last, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    $display("dump midrst first=4 last=7 reset");
    run_dump(3'd2, 3'd5, 100, 0, "after_rst", n_got, d_first, d_last, hs);

    // Random dumps against the model regfile.
    for (int r = 0; r < 20; r++) begin
      wr(3'($urandom_range(7)), 16'($urandom));
      wr(3'($urandom_range(7)), 16'($urandom));
      run_dump(3'($urandom_range(7)), 3'($urandom_range(7)), $urandom_range(100, 30),
               $urandom_range(4), $sformatf("rand%0d", r), n_got, d_first, d_last, hs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
